// File: rtl/rom_passcode_verifier.sv
// rom_passcode_verifier: multi-digit passcode checker against an external synchronous ROM.
// Each accepted Password_Enter rising edge consumes one digit. The digit is compared with
// the ROM word at BASE_ADDR + digit index. A mismatch on any digit fails the whole attempt.
// Optional feature macro: ROM_PASSCODE_LOCKOUT_EN. It locks out strobes for LOCK_CYCLES
// cycles after MAX_FAILS consecutive failed attempts.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous reset, active-high
//   Password_Enter digit strobe, only the 0->1 transition seen in IDLE is accepted
//   Password       digit value, latched on an accepted strobe
//   Logout         level, leaves the logged-in state
//   q_ROM          ROM read data, sampled ROM_LAT cycles after ROM_addr changes
//   ROM_addr       ROM read address
//   Busy           high while a digit fetch/compare is in flight
//   Logged_In      high while authenticated
//   Logged_Out     complement of Logged_In
//   Passed         one-cycle pulse on a successful attempt
//   Failed         one-cycle pulse on a failed attempt
//   Locked         high during lockout (tied low without the lockout feature)
module rom_passcode_verifier #(
  parameter int unsigned DIGIT_W     = 4,
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned ROM_LAT     = 2,
  parameter int unsigned MAX_FAILS   = 3,
  parameter int unsigned LOCK_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Password_Enter,
  input  logic [DIGIT_W-1:0] Password,
  input  logic               Logout,
  input  logic [DIGIT_W-1:0] q_ROM,
  output logic [ADDR_W-1:0]  ROM_addr,
  output logic               Busy,
  output logic               Logged_In,
  output logic               Logged_Out,
  output logic               Passed,
  output logic               Failed,
  output logic               Locked
);

  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  // Wait counter holds ROM_LAT-1 down to 0.
  localparam int unsigned WAIT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(ROM_LAT - 1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  // Elaboration-time parameter sanity checks.
  if (NUM_DIGITS < 1) begin : g_chk_digits
    $error("rom_passcode_verifier: NUM_DIGITS must be >= 1");
  end
  if (ROM_LAT < 1) begin : g_chk_lat
    $error("rom_passcode_verifier: ROM_LAT must be >= 1");
  end
  if (BASE_ADDR + NUM_DIGITS > (1 << ADDR_W)) begin : g_chk_addr
    $error("rom_passcode_verifier: passcode does not fit in the ROM address space");
  end
  if (MAX_FAILS < 1 || LOCK_CYCLES < 1) begin : g_chk_lock
    $error("rom_passcode_verifier: MAX_FAILS and LOCK_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_ROM_WAIT  = 3'd2,
    S_COMPARE   = 3'd3,
    S_NEXT      = 3'd4,
    S_VERIFY    = 3'd5,
    S_LOGGED_IN = 3'd6,
    S_LOCKED    = 3'd7
  } state_t;

  state_t              state, state_n;
  logic                pe_q;
  logic [DIGIT_W-1:0]  digit_q, digit_n;
  logic [DIGIT_W-1:0]  word_q, word_n;
  logic [IDX_W-1:0]    idx_q, idx_n;
  logic                mismatch_q, mismatch_n;
  logic [WAIT_W-1:0]   wait_q, wait_n;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_n;
  logic                busy_q, busy_n;
  logic                logged_in_q, logged_in_n;
  logic                passed_q, passed_n;
  logic                failed_q, failed_n;
  logic                strobe_rise_c;

`ifdef ROM_PASSCODE_LOCKOUT_EN
  localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int unsigned LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_INIT = LOCK_W'(LOCK_CYCLES - 1);

  logic [FAIL_W-1:0] fail_cnt_q, fail_cnt_n;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_n;
  logic              locked_q, locked_n;
`endif

  // Rising edge of the strobe relative to its registered copy.
  assign strobe_rise_c = Password_Enter & ~pe_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pe_q        <= 1'b0;
      digit_q     <= '0;
      word_q      <= '0;
      idx_q       <= '0;
      mismatch_q  <= 1'b0;
      wait_q      <= '0;
      rom_addr_q  <= BASE;
      busy_q      <= 1'b0;
      logged_in_q <= 1'b0;
      passed_q    <= 1'b0;
      failed_q    <= 1'b0;
`ifdef ROM_PASSCODE_LOCKOUT_EN
      fail_cnt_q  <= '0;
      lock_cnt_q  <= '0;
      locked_q    <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      pe_q        <= Password_Enter;
      digit_q     <= digit_n;
      word_q      <= word_n;
      idx_q       <= idx_n;
      mismatch_q  <= mismatch_n;
      wait_q      <= wait_n;
      rom_addr_q  <= rom_addr_n;
      busy_q      <= busy_n;
      logged_in_q <= logged_in_n;
      passed_q    <= passed_n;
      failed_q    <= failed_n;
`ifdef ROM_PASSCODE_LOCKOUT_EN
      fail_cnt_q  <= fail_cnt_n;
      lock_cnt_q  <= lock_cnt_n;
      locked_q    <= locked_n;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state;
    digit_n     = digit_q;
    word_n      = word_q;
    idx_n       = idx_q;
    mismatch_n  = mismatch_q;
    wait_n      = wait_q;
    rom_addr_n  = rom_addr_q;
    busy_n      = busy_q;
    logged_in_n = logged_in_q;
    passed_n    = 1'b0;
    failed_n    = 1'b0;
`ifdef ROM_PASSCODE_LOCKOUT_EN
    fail_cnt_n  = fail_cnt_q;
    lock_cnt_n  = lock_cnt_q;
    locked_n    = locked_q;
`endif

    unique case (state)
      S_IDLE: begin
        // Busy rises with the accepted strobe so it covers the whole digit.
        if (strobe_rise_c) begin
          digit_n = Password;
          busy_n  = 1'b1;
          state_n = S_FETCH;
        end
      end

      S_FETCH: begin
        rom_addr_n = BASE + ADDR_W'(idx_q);
        busy_n     = 1'b1;
        wait_n     = WAIT_INIT;
        state_n    = S_ROM_WAIT;
      end

      S_ROM_WAIT: begin
        if (wait_q == '0) begin
          word_n  = q_ROM;
          state_n = S_COMPARE;
        end else begin
          wait_n = wait_q - WAIT_W'(1);
        end
      end

      S_COMPARE: begin
        // Sticky: only ever set here, cleared when the attempt is verified.
        if (digit_q != word_q) begin
          mismatch_n = 1'b1;
        end
        state_n = S_NEXT;
      end

      S_NEXT: begin
        busy_n = 1'b0;
        if (idx_q == LAST_IDX) begin
          state_n = S_VERIFY;
        end else begin
          idx_n   = idx_q + IDX_W'(1);
          state_n = S_IDLE;
        end
      end

      S_VERIFY: begin
        idx_n      = '0;
        mismatch_n = 1'b0;
        busy_n     = 1'b0;
        if (!mismatch_q) begin
          passed_n    = 1'b1;
          logged_in_n = 1'b1;
          state_n     = S_LOGGED_IN;
`ifdef ROM_PASSCODE_LOCKOUT_EN
          fail_cnt_n  = '0;
`endif
        end else begin
          failed_n = 1'b1;
          state_n  = S_IDLE;
`ifdef ROM_PASSCODE_LOCKOUT_EN
          fail_cnt_n = fail_cnt_q + FAIL_W'(1);
          if (32'(fail_cnt_q) + 32'd1 >= 32'(MAX_FAILS)) begin
            locked_n   = 1'b1;
            lock_cnt_n = LOCK_INIT;
            state_n    = S_LOCKED;
          end
`endif
        end
      end

      S_LOGGED_IN: begin
        if (Logout) begin
          logged_in_n = 1'b0;
          state_n     = S_IDLE;
        end
      end

      S_LOCKED: begin
`ifdef ROM_PASSCODE_LOCKOUT_EN
        if (lock_cnt_q == '0) begin
          locked_n   = 1'b0;
          fail_cnt_n = '0;
          state_n    = S_IDLE;
        end else begin
          lock_cnt_n = lock_cnt_q - LOCK_W'(1);
        end
`else
        state_n = S_IDLE;
`endif
      end

      default: state_n = S_IDLE;
    endcase
  end

  assign ROM_addr   = rom_addr_q;
  assign Busy       = busy_q;
  assign Logged_In  = logged_in_q;
  assign Logged_Out = ~logged_in_q;
  assign Passed     = passed_q;
  assign Failed     = failed_q;
`ifdef ROM_PASSCODE_LOCKOUT_EN
  assign Locked     = locked_q;
`else
  assign Locked     = 1'b0;
`endif

endmodule

// File: tb/tb_rom_passcode_verifier.sv
// Testbench for rom_passcode_verifier: directed scenarios followed by randomized attempts,
// checked against a passcode-level reference model (expected outcome = entered code equals
// ROM contents, plus a consecutive-failure count for the optional lockout).
module tb_rom_passcode_verifier;

  localparam int unsigned DW          = 4;
  localparam int unsigned ND          = 4;
  localparam int unsigned AW          = 5;
  localparam int unsigned BASE        = 0;
  localparam int unsigned ROM_LAT     = 2;
  localparam int unsigned MAX_FAILS   = 3;
  localparam int unsigned LOCK_CYCLES = 16;
`ifdef ROM_PASSCODE_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          Password_Enter;
  logic [DW-1:0] Password;
  logic          Logout;
  logic [DW-1:0] q_ROM;
  logic [AW-1:0] ROM_addr;
  logic          Busy, Logged_In, Logged_Out, Passed, Failed, Locked;

  logic [DW-1:0] mem [2**AW];
  int            n_vec;
  int            n_err;
  int            model_fails;

  rom_passcode_verifier #(
    .DIGIT_W(DW), .NUM_DIGITS(ND), .ADDR_W(AW), .BASE_ADDR(BASE), .ROM_LAT(ROM_LAT),
    .MAX_FAILS(MAX_FAILS), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .Password_Enter(Password_Enter), .Password(Password),
    .Logout(Logout), .q_ROM(q_ROM), .ROM_addr(ROM_addr), .Busy(Busy),
    .Logged_In(Logged_In), .Logged_Out(Logged_Out), .Passed(Passed), .Failed(Failed),
    .Locked(Locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: ROM_LAT-1 = 1 internal register stage, data sampled ROM_LAT edges later.
  always @(posedge clk) q_ROM <= mem[ROM_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Invariants sampled every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      check("in_out_compl", 32'(Logged_In ^ Logged_Out), 32'd1);
      check("pass_fail_excl", 32'(Passed & Failed), 32'd0);
      if (!LOCK_EN) check("locked_tied", 32'(Locked), 32'd0);
    end
  end

  function automatic logic [ND*DW-1:0] rom_code();
    logic [ND*DW-1:0] c;
    for (int i = 0; i < ND; i++) c[i*DW +: DW] = mem[BASE + i];
    return c;
  endfunction

  // One digit: strobe, optional extra strobe while busy, check busy window and address.
  task automatic press(input logic [DW-1:0] d, input int idx, input bit glitch);
    int cnt;
    int guard;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    Password = d;
    Password_Enter = 1'b1;
    @(negedge clk);
    Password_Enter = 1'b0;
    Password = DW'($urandom);
    cnt = 0;
    guard = 0;
    while (Busy === 1'b1 && guard < 40) begin
      cnt++;
      guard++;
      if (glitch && cnt == 2) Password_Enter = 1'b1;
      if (glitch && cnt == 3) Password_Enter = 1'b0;
      @(negedge clk);
    end
    check("busy_len", 32'(cnt), 32'(ROM_LAT + 3));
    check("rom_addr", 32'(ROM_addr), 32'(BASE + idx));
  endtask

  // One digit with the strobe held high for 20 cycles.
  task automatic press_held(input logic [DW-1:0] d, input int idx);
    int cnt;
    @(negedge clk);
    Password = d;
    Password_Enter = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (Busy === 1'b1) cnt++;
    end
    Password_Enter = 1'b0;
    check("held_busy_len", 32'(cnt), 32'(ROM_LAT + 3));
    check("held_rom_addr", 32'(ROM_addr), 32'(BASE + idx));
  endtask

  // Outcome of the attempt: pulse, login state, lockout, logout.
  task automatic finish_attempt(input bit exp_pass);
    bit lock_exp;
    int cnt;
    int guard;
    bit busy_seen;
    @(negedge clk);
    check("passed_pulse", 32'(Passed), 32'(exp_pass));
    check("failed_pulse", 32'(Failed), 32'(!exp_pass));
    if (exp_pass) begin
      model_fails = 0;
      lock_exp = 1'b0;
    end else begin
      model_fails++;
      lock_exp = LOCK_EN && (model_fails >= MAX_FAILS);
    end
    check("locked_start", 32'(Locked), 32'(lock_exp));
    check("logged_in", 32'(Logged_In), 32'(exp_pass));
    @(negedge clk);
    check("pulse_width", 32'({Passed, Failed}), 32'd0);
    if (lock_exp) begin
      cnt = 1;
      guard = 0;
      busy_seen = 1'b0;
      while (Locked === 1'b1 && guard < LOCK_CYCLES + 8) begin
        cnt++;
        guard++;
        if (cnt == 4) begin
          Password = DW'($urandom);
          Password_Enter = 1'b1;
        end
        if (cnt == 6) Password_Enter = 1'b0;
        if (Busy === 1'b1) busy_seen = 1'b1;
        @(negedge clk);
      end
      check("lock_len", 32'(cnt), 32'(LOCK_CYCLES));
      check("lock_strobe_ignored", 32'(busy_seen), 32'd0);
      model_fails = 0;
    end
    if (exp_pass) begin
      @(negedge clk);
      Password_Enter = 1'b1;
      @(negedge clk);
      check("login_strobe_ignored", 32'(Busy), 32'd0);
      Password_Enter = 1'b0;
      Logout = 1'b1;
      @(negedge clk);
      Logout = 1'b0;
      check("logout_out", 32'(Logged_Out), 32'd1);
      check("logout_in", 32'(Logged_In), 32'd0);
    end
  endtask

  task automatic do_attempt(input logic [ND*DW-1:0] code);
    bit exp_pass;
    exp_pass = (code == rom_code());
    for (int i = 0; i < ND; i++) press(code[i*DW +: DW], i, 1'b0);
    finish_attempt(exp_pass);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ND*DW-1:0] good;
    logic [ND*DW-1:0] bad;
    logic [ND*DW-1:0] code;
    n_vec = 0;
    n_err = 0;
    model_fails = 0;
    rst = 1'b1;
    Password_Enter = 1'b0;
    Password = '0;
    Logout = 1'b0;
    for (int a = 0; a < 2**AW; a++) mem[a] = DW'($urandom);
    mem[0] = 4'h3; mem[1] = 4'hA; mem[2] = 4'h7; mem[3] = 4'h1;
    good = {4'h1, 4'h7, 4'hA, 4'h3};
    bad  = {4'h1, 4'h7, 4'hB, 4'h3};

    // Reset defaults.
    repeat (2) @(negedge clk);
    check("rst_rom_addr", 32'(ROM_addr), 32'(BASE));
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_logged_in", 32'(Logged_In), 32'd0);
    check("rst_logged_out", 32'(Logged_Out), 32'd1);
    check("rst_pf", 32'({Passed, Failed}), 32'd0);
    check("rst_locked", 32'(Locked), 32'd0);
    rst = 1'b0;

    // Correct code, sticky mismatch, then a correct retry.
    do_attempt(good);
    do_attempt(bad);
    do_attempt(good);

    // Held-high strobe consumes one digit; a strobe during Busy is ignored.
    press_held(4'h3, 0);
    press(4'hA, 1, 1'b1);
    press(4'h7, 2, 1'b1);
    press(4'h1, 3, 1'b0);
    finish_attempt(1'b1);

    // Reset after two digits restarts the attempt from digit 0 with no Failed pulse.
    press(4'h3, 0, 1'b0);
    press(4'hA, 1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("midrst_failed", 32'(Failed), 32'd0);
    end
    check("midrst_rom_addr", 32'(ROM_addr), 32'(BASE));
    check("midrst_busy", 32'(Busy), 32'd0);
    rst = 1'b0;
    model_fails = 0;
    do_attempt(good);

    // Three wrong codes (lockout when enabled), then the correct code.
    do_attempt(bad);
    do_attempt({4'h0, 4'h7, 4'hA, 4'h3});
    do_attempt({4'h1, 4'h7, 4'hA, 4'h4});
    do_attempt(good);

    // Randomized attempts against new ROM contents.
    for (int i = 0; i < ND; i++) mem[BASE + i] = DW'($urandom);
    for (int t = 0; t < 14; t++) begin
      code = rom_code();
      case ($urandom_range(0, 3))
        0, 1: ;
        2: code[$urandom_range(0, ND - 1) * DW +: DW] ^= DW'($urandom_range(1, 2**DW - 1));
        default: code = (ND*DW)'({$urandom, $urandom});
      endcase
      do_attempt(code);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
